mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 179 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shared memory port arbiter for the fetch and memory stages.
// Data wins ties unless fetch has been passed over STARVE_MAX times.
//
// Ports:
//   clk, reset              clock, asynchronous active-low reset
//   if_req/if_addr          fetch read request (held until if_ready)
//   if_rdata/if_ready       fetch read data and completion pulse
//   dm_req/dm_we/dm_addr    memory-stage request (held until dm_ready)
//   dm_wdata                memory-stage store data
//   dm_rdata/dm_ready       load data and completion pulse
//   mem_req/mem_we          request/write-enable to shared memory
//   mem_addr/mem_wdata      registered address and store data
//   mem_rdata/mem_ack       memory read data and completion strobe
//   stall_if/stall_mem      stall while own request is outstanding
//   err                     sticky timeout flag

module mem_port_arbiter #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 64,
   parameter int STARVE_MAX = 4,
   parameter int TIMEOUT    = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_ready,
   input  logic              dm_req,
   input  logic              dm_we,
   input  logic [ADDR_W-1:0] dm_addr,
   input  logic [DATA_W-1:0] dm_wdata,
   output logic [DATA_W-1:0] dm_rdata,
   output logic              dm_ready,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack,
   output logic              stall_if,
   output logic              stall_mem,
   output logic              err
);

   localparam int SW = $clog2(STARVE_MAX + 1);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [SW-1:0] SMAX  = SW'(STARVE_MAX);
   localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      IDLE,
      BUSY_IF,
      BUSY_DM,
      DONE_IF,
      DONE_DM
   } state_t;

   state_t            state_q, state_d;
   logic              mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
   logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
   logic [SW-1:0]     streak_q, streak_d;
   logic [TW-1:0]     tmo_q, tmo_d;
   logic              err_q, err_d;

   logic dm_win;

   // Data goes first unless fetch is waiting and has hit its starvation cap.
   assign dm_win = dm_req & (~if_req | (streak_q < SMAX));

   always_comb begin
      state_d     = state_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      if_rdata_d  = if_rdata_q;
      dm_rdata_d  = dm_rdata_q;
      streak_d    = streak_q;
      tmo_d       = tmo_q;
      err_d       = err_q;

      unique case (state_q)
         IDLE: begin
            tmo_d = '0;
            if (!if_req) begin
               streak_d = '0;
            end
            if (dm_win) begin
               state_d     = BUSY_DM;
               mem_we_d    = dm_we;
               mem_addr_d  = dm_addr;
               mem_wdata_d = dm_wdata;
               if (if_req && streak_q < SMAX) begin
                  streak_d = streak_q + SW'(1);
               end
            end else if (if_req) begin
               state_d    = BUSY_IF;
               mem_we_d   = 1'b0;
               mem_addr_d = if_addr;
               streak_d   = '0;
            end
         end

         BUSY_IF, BUSY_DM: begin
            tmo_d = tmo_q + TW'(1);
            if (mem_ack) begin
               if (state_q == BUSY_IF) begin
                  if_rdata_d = mem_rdata;
                  state_d    = DONE_IF;
               end else begin
                  // A store completion must not disturb the last load data.
                  if (!mem_we_q) begin
                     dm_rdata_d = mem_rdata;
                  end
                  state_d = DONE_DM;
               end
            end else if (tmo_q == TLAST) begin
               // Give up: flag the error and release the requester with 0.
               err_d = 1'b1;
               if (state_q == BUSY_IF) begin
                  if_rdata_d = '0;
                  state_d    = DONE_IF;
               end else begin
                  dm_rdata_d = '0;
                  state_d    = DONE_DM;
               end
            end
         end

         DONE_IF, DONE_DM: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         if_rdata_q  <= '0;
         dm_rdata_q  <= '0;
         streak_q    <= '0;
         tmo_q       <= '0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         if_rdata_q  <= if_rdata_d;
         dm_rdata_q  <= dm_rdata_d;
         streak_q    <= streak_d;
         tmo_q       <= tmo_d;
         err_q       <= err_d;
      end
   end

   assign mem_req   = (state_q == BUSY_IF) | (state_q == BUSY_DM);
   assign mem_we    = mem_we_q & (state_q == BUSY_DM);
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign if_rdata  = if_rdata_q;
   assign dm_rdata  = dm_rdata_q;
   assign if_ready  = (state_q == DONE_IF);
   assign dm_ready  = (state_q == DONE_DM);
   assign stall_if  = if_req & ~if_ready;
   assign stall_mem = dm_req & ~dm_ready;
   assign err       = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: vector table, corner
// sequences and a randomized run against a memory/fairness model.

module tb_mem_port_arbiter;

   localparam int AW   = 32;
   localparam int DW   = 64;
   localparam int SMAX = 4;
   localparam int TMO  = 64;

   logic          clk = 1'b0;
   logic          reset;
   logic          if_req = 1'b0;
   logic [AW-1:0] if_addr = '0;
   logic [DW-1:0] if_rdata;
   logic          if_ready;
   logic          dm_req = 1'b0;
   logic          dm_we = 1'b0;
   logic [AW-1:0] dm_addr = '0;
   logic [DW-1:0] dm_wdata = '0;
   logic [DW-1:0] dm_rdata;
   logic          dm_ready;
   logic          mem_req;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata = '0;
   logic          mem_ack = 1'b0;
   logic          stall_if;
   logic          stall_mem;
   logic          err;

   always #5 clk = ~clk;

   mem_port_arbiter #(
      .ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX), .TIMEOUT(TMO)
   ) dut (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr),
      .if_rdata(if_rdata), .if_ready(if_ready),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
      .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_ready(dm_ready),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
      .stall_if(stall_if), .stall_mem(stall_mem), .err(err)
   );

   int n_chk  = 0;
   int n_fail = 0;

   function automatic logic [63:0] pat(input int i);
      if (i == 2) return 64'h0000_0000_0010_0093;
      return {32'hA5A5_0000 | 32'(i), 32'h1234_0000 | 32'(i)};
   endfunction

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Memory responder: acks after ack_dly wait cycles (-1 = never).
   int          ack_dly  = 0;
   int          init_gen = 0;
   int          seen_gen = -1;
   int          wcnt     = 0;
   logic [63:0] rmem [16];

   always @(negedge clk) begin
      if (seen_gen != init_gen) begin
         for (int i = 0; i < 16; i++) rmem[i] = pat(i);
         seen_gen = init_gen;
      end
      if (mem_req && !mem_ack) begin
         if (ack_dly >= 0 && wcnt >= ack_dly) begin
            mem_ack = 1'b1;
            if (mem_we) begin
               rmem[mem_addr[6:3]] = mem_wdata;
               mem_rdata = ~mem_wdata;
            end else begin
               mem_rdata = rmem[mem_addr[6:3]];
            end
         end else begin
            wcnt++;
         end
      end else begin
         mem_ack   = 1'b0;
         wcnt      = 0;
         mem_rdata = 64'h0BAD_C0DE_0BAD_C0DE;
      end
   end

   typedef struct {
      string       nm;
      bit          dm;
      bit          we;
      logic [31:0] addr;
      logic [63:0] wdata;
      int          dly;
      logic [63:0] exp_rdata;
      int          exp_lat;
   } vec_t;

   vec_t tbl [7];

   task automatic do_reset();
      reset  = 1'b0;
      if_req = 1'b0;
      dm_req = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic do_txn(input vec_t v);
      int n;
      bit got, we_bad, a_bad, other;
      @(negedge clk);
      chk({v.nm, "_idle_ready"}, 64'(if_ready | dm_ready), 0);
      ack_dly = v.dly;
      if (v.dm) begin
         dm_req = 1'b1; dm_we = v.we;
         dm_addr = v.addr; dm_wdata = v.wdata;
      end else begin
         if_req = 1'b1; if_addr = v.addr;
      end
      #1;
      chk({v.nm, "_stall"}, 64'(v.dm ? stall_mem : stall_if), 1);
      n = 0; got = 0; we_bad = 0; a_bad = 0; other = 0;
      while (!got && n < 200) begin
         @(negedge clk);
         n++;
         if (mem_req) begin
            if (mem_we !== (v.dm & v.we)) we_bad = 1;
            if (mem_addr !== v.addr) a_bad = 1;
         end
         if (v.dm ? if_ready : dm_ready) other = 1;
         got = v.dm ? dm_ready : if_ready;
      end
      chk({v.nm, "_ready"}, 64'(got), 1);
      chk({v.nm, "_latency"}, 64'(n), 64'(v.exp_lat));
      chk({v.nm, "_rdata"}, v.dm ? dm_rdata : if_rdata, v.exp_rdata);
      chk({v.nm, "_mem_we"}, 64'(we_bad), 0);
      chk({v.nm, "_mem_addr"}, 64'(a_bad), 0);
      chk({v.nm, "_other_ready"}, 64'(other), 0);
      if (v.dm) dm_req = 1'b0;
      else if_req = 1'b0;
   endtask

   // Randomized-phase model state
   logic [63:0] mmem [16];
   bit          if_pend, dm_pend, dm_we_m, draining;
   logic [3:0]  if_a, dm_a;
   logic [63:0] dm_wdata_m;
   int          starve, if_wait, cyc, g, stall_bad;
   bit          seen_if, rdy_seen;
   vec_t        v;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0] = '{"fetch",   0, 0, 32'h10, 64'd0,   0, 64'h0010_0093, 2};
      tbl[1] = '{"sw",      1, 1, 32'h20, 64'd100, 0, 64'd0,         2};
      tbl[2] = '{"lw",      1, 0, 32'h20, 64'd0,   0, 64'd100,       2};
      tbl[3] = '{"fetch_w", 0, 0, 32'h20, 64'd0,   2, 64'd100,       4};
      tbl[4] = '{"sw2",     1, 1, 32'h28, 64'hDEAD_BEEF, 1,
                 64'd100, 3};
      tbl[5] = '{"lw2",     1, 0, 32'h28, 64'd0,   3, 64'hDEAD_BEEF, 5};
      tbl[6] = '{"fetch2",  0, 0, 32'h28, 64'd0,   1, 64'hDEAD_BEEF, 3};

      // Reset values
      do_reset();
      #1;
      chk("rst_mem_req", 64'(mem_req), 0);
      chk("rst_mem_we", 64'(mem_we), 0);
      chk("rst_mem_addr", 64'(mem_addr), 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_ready", 64'({if_ready, dm_ready}), 0);
      chk("rst_if_rdata", if_rdata, 0);
      chk("rst_dm_rdata", dm_rdata, 0);
      chk("rst_err", 64'(err), 0);
      chk("rst_stall", 64'({stall_if, stall_mem}), 0);

      // Vector table
      for (int i = 0; i < 7; i++) do_txn(tbl[i]);

      // Contention after reset: DM x4 then IF, repeating
      do_reset();
      @(negedge clk);
      ack_dly = 0;
      if_req = 1'b1; if_addr = 32'h10;
      dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h18;
      g = 0; cyc = 0; stall_bad = 0; seen_if = 0;
      while (g < 10 && cyc < 200) begin
         @(negedge clk);
         cyc++;
         if (!seen_if && !if_ready && stall_if !== 1'b1) stall_bad++;
         if (if_ready && stall_if !== 1'b0) stall_bad++;
         if (dm_ready || if_ready) begin
            chk($sformatf("cont_grant%0d_is_dm", g), 64'(dm_ready),
                64'((g % 5) != 4));
            g++;
         end
         if (if_ready) seen_if = 1;
      end
      chk("cont_count", 64'(g), 10);
      chk("cont_stall_if", 64'(stall_bad), 0);
      if_req = 1'b0;
      dm_req = 1'b0;
      @(negedge clk);

      // Timeout, then sticky err across a normal access
      chk("tmo_err_before", 64'(err), 0);
      v = '{"tmo", 1, 0, 32'h30, 64'd0, -1, 64'd0, TMO + 1};
      do_txn(v);
      chk("tmo_err", 64'(err), 1);
      v = '{"post_tmo", 1, 0, 32'h10, 64'd0, 0, 64'h0010_0093, 2};
      do_txn(v);
      chk("tmo_err_sticky", 64'(err), 1);

      // Reset two cycles into a data access
      @(negedge clk);
      ack_dly = -1;
      dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h30;
      repeat (2) @(negedge clk);
      chk("rstb_busy", 64'(mem_req), 1);
      reset = 1'b0;
      #1;
      chk("rstb_mem_req", 64'(mem_req), 0);
      chk("rstb_mem_addr", 64'(mem_addr), 0);
      chk("rstb_mem_we", 64'(mem_we), 0);
      chk("rstb_if_rdata", if_rdata, 0);
      chk("rstb_dm_rdata", dm_rdata, 0);
      chk("rstb_err", 64'(err), 0);
      rdy_seen = 0;
      repeat (3) begin
         @(negedge clk);
         if (dm_ready || if_ready) rdy_seen = 1;
      end
      chk("rstb_no_ready", 64'(rdy_seen), 0);
      dm_req = 1'b0;
      reset = 1'b1;
      repeat (3) begin
         @(negedge clk);
         if (dm_ready || mem_req) rdy_seen = 1;
      end
      chk("rstb_aborted", 64'(rdy_seen), 0);

      // Randomized traffic against memory/fairness model
      init_gen++;
      for (int i = 0; i < 16; i++) mmem[i] = pat(i);
      do_reset();
      if_pend = 0; dm_pend = 0; starve = 0; if_wait = 0;
      draining = 0; cyc = 0;
      while (cyc < 3300) begin
         @(negedge clk);
         cyc++;
         if (cyc >= 3000) draining = 1;
         if (if_ready) begin
            chk("rnd_if_pending", 64'(if_pend), 1);
            if (if_pend) chk("rnd_if_rdata", if_rdata, mmem[if_a]);
            if_pend = 0; if_req = 1'b0; starve = 0; if_wait = 0;
         end
         if (dm_ready) begin
            chk("rnd_dm_pending", 64'(dm_pend), 1);
            if (dm_pend) begin
               if (dm_we_m) mmem[dm_a] = dm_wdata_m;
               else chk("rnd_dm_rdata", dm_rdata, mmem[dm_a]);
            end
            if (if_pend) begin
               starve++;
               chk("rnd_starve", 64'(starve <= SMAX), 1);
            end
            dm_pend = 0; dm_req = 1'b0;
         end
         if (if_pend) begin
            if_wait++;
            if (if_wait == 100) chk("rnd_if_wait", 64'(if_wait), 0);
         end
         if (!mem_req) ack_dly = int'($urandom_range(0, 2));
         if (!draining && !if_pend && $urandom_range(0, 2) == 0) begin
            if_a    = 4'($urandom_range(0, 15));
            if_addr = {25'd0, if_a, 3'b000};
            if_req  = 1'b1;
            if_pend = 1;
            starve  = mem_req ? -1 : 0;
         end
         if (!draining && !dm_pend && $urandom_range(0, 2) == 0) begin
            dm_a       = 4'($urandom_range(0, 15));
            dm_we_m    = 1'($urandom_range(0, 1));
            dm_wdata_m = {$urandom, $urandom};
            dm_addr    = {25'd0, dm_a, 3'b000};
            dm_we      = dm_we_m;
            dm_wdata   = dm_wdata_m;
            dm_req     = 1'b1;
            dm_pend    = 1;
         end
         if (draining && !if_pend && !dm_pend) break;
      end
      chk("rnd_drained", 64'({if_pend, dm_pend}), 0);
      chk("rnd_err", 64'(err), 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
